pc_seq: RTL and testbench

Parametrised program-counter sequencer for the single-cycle CPU: the successor to the fixed 32-bit PC+4 counter. It holds the current instruction address and computes the next one each clock. The next address is chosen from sequential increment, PC-relative branch/jump, or return-from-call through an internal return-address stack (RAS). It also supports stall and a terminal halt state. It drives the instruction-memory address and feeds PC+STEP to the datapath for branch-target arithmetic.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_ras.sv | 49 ++++
 rtl/pc_seq.sv | 104 ++++++++++
 tb/tb_pc_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

    localparam int          DEF_WIDTH     = 32;
    localparam int          DEF_STEP      = 4;
    localparam int          DEF_OFF_W     = 8;
    localparam int          DEF_DEPTH     = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH x WIDTH LIFO. Overflowing pushes and
// underflowing pops are silently dropped; the caller tracks errors.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]     count_reg;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic [WIDTH-1:0]   mem [DEPTH];

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == (PTR_W+1)'(DEPTH));
    assign wr_idx = count_reg[PTR_W-1:0];
    // On an empty stack this wraps to the last entry; top is don't-care then.
    assign rd_idx = count_reg[PTR_W-1:0] - PTR_W'(1);
    assign top    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential/relative/return next-PC selection,
// stall, terminal halt and a sticky RAS overflow/underflow flag.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STEP      = DEF_STEP,
    parameter int               OFF_W     = DEF_OFF_W,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             HALT,
    input  logic             JUMP,
    input  logic             BRANCH_TAKEN,
    input  logic             CALL,
    input  logic             RET,
    input  logic [OFF_W-1:0] OFFSET,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_PLUS,
    output logic             HALTED,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             ERR
);

    pc_state_t        state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push, ras_pop;

    // Offset counts instructions; scale to bytes and wrap at WIDTH bits.
    assign off_ext = WIDTH'($signed(OFFSET));
    assign PC_PLUS = pc_reg + WIDTH'(STEP);
    assign target  = PC_PLUS + off_ext * WIDTH'(STEP);

    assign PC     = pc_reg;
    assign HALTED = (state_reg == ST_HALT);
    assign ERR    = err_reg;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (PC_PLUS),
        .top       (ras_top),
        .empty     (RAS_EMPTY),
        .full      (RAS_FULL)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        err_next   = err_reg;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (state_reg == ST_RUN && !STALL) begin
            if (HALT) begin
                state_next = ST_HALT;
            end else if (RET) begin
                if (RAS_EMPTY) begin
                    pc_next  = PC_PLUS;
                    err_next = 1'b1;
                end else begin
                    pc_next = ras_top;
                    ras_pop = 1'b1;
                end
            end else if (JUMP || BRANCH_TAKEN) begin
                pc_next = target;
                if (CALL && JUMP) begin
                    if (RAS_FULL) begin
                        err_next = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
                end
            end else begin
                pc_next = PC_PLUS;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_VEC;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a default 32-bit instance plus an 8-bit instance
// started near the top of its address space to exercise wrap-around.
module tb_pc_seq;

    logic        CLK;
    logic        RESET;
    logic        STALL, HALT, JUMP, BRANCH_TAKEN, CALL, RET;
    logic [7:0]  OFFSET;
    logic [31:0] PC, PC_PLUS;
    logic        HALTED, RAS_EMPTY, RAS_FULL, ERR;

    logic [7:0]  pc_b, pc_plus_b;
    logic        halted_b, empty_b, full_b, err_b;

    int errors = 0;
    int checks = 0;

    pc_seq dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (STALL),
        .HALT         (HALT),
        .JUMP         (JUMP),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .CALL         (CALL),
        .RET          (RET),
        .OFFSET       (OFFSET),
        .PC           (PC),
        .PC_PLUS      (PC_PLUS),
        .HALTED       (HALTED),
        .RAS_EMPTY    (RAS_EMPTY),
        .RAS_FULL     (RAS_FULL),
        .ERR          (ERR)
    );

    pc_seq #(
        .WIDTH     (8),
        .RESET_VEC (8'hF8)
    ) dut_w8 (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (1'b0),
        .HALT         (1'b0),
        .JUMP         (1'b0),
        .BRANCH_TAKEN (1'b0),
        .CALL         (1'b0),
        .RET          (1'b0),
        .OFFSET       (8'h00),
        .PC           (pc_b),
        .PC_PLUS      (pc_plus_b),
        .HALTED       (halted_b),
        .RAS_EMPTY    (empty_b),
        .RAS_FULL     (full_b),
        .ERR          (err_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic stall, input logic halt, input logic jump,
                         input logic br, input logic call, input logic ret,
                         input logic [7:0] off);
        STALL = stall; HALT = halt; JUMP = jump;
        BRANCH_TAKEN = br; CALL = call; RET = ret; OFFSET = off;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Outputs are sampled 2 time units after the active edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        #1 RESET = 1'b0;
        #2;
        check("rst_pc", PC, 32'h0);
        check("rst_pc_plus", PC_PLUS, 32'h4);
        check("rst_empty", RAS_EMPTY, 1'b1);
        check("rst_full", RAS_FULL, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_halted", HALTED, 1'b0);
        check("rst_w8_pc", pc_b, 8'hF8);
        #9 RESET = 1'b1;

        tick();
        check("seq_pc1", PC, 32'h4);
        check("w8_pc1", pc_b, 8'hFC);
        check("w8_plus_wrap", pc_plus_b, 8'h00);
        tick();
        check("seq_pc2", PC, 32'h8);
        check("seq_plus2", PC_PLUS, 32'hC);
        check("w8_wrap", pc_b, 8'h00);
        tick();
        check("seq_pc3", PC, 32'hC);
        check("w8_pc3", pc_b, 8'h04);
        for (int i = 0; i < 5; i++) tick();
        check("seq_0x20", PC, 32'h20);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFD);
        tick();
        check("branch_neg3", PC, 32'h18);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd127);
        tick();
        check("jump_127", PC, 32'h218);
        idle();

        pulse_reset();
        for (int i = 0; i < 4; i++) tick();
        check("call_setup", PC, 32'h10);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
        tick();
        check("call_pc", PC, 32'h24);
        check("call_not_empty", RAS_EMPTY, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        check("ret_pc", PC, 32'h14);
        check("ret_empty", RAS_EMPTY, 1'b1);
        check("ret_err", ERR, 1'b0);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("nest_pc%0d", i), PC, 32'h18 + 32'(4 * i));
        end
        check("nest_full", RAS_FULL, 1'b1);
        check("nest_err0", ERR, 1'b0);
        tick();
        check("overflow_pc", PC, 32'h28);
        check("overflow_err", ERR, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        check("pop1_pc", PC, 32'h24);
        check("pop1_full", RAS_FULL, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("pop%0d_pc", i + 1), PC, 32'h24 - 32'(4 * i));
        end
        check("pop4_empty", RAS_EMPTY, 1'b1);
        tick();
        check("underflow_pc", PC, 32'h1C);
        check("underflow_err", ERR, 1'b1);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
        tick();
        check("call2_pc", PC, 32'h28);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
        tick();
        check("ret_wins_pc", PC, 32'h20);
        check("ret_wins_empty", RAS_EMPTY, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
        tick();
        check("call_only_pc", PC, 32'h24);
        check("call_only_empty", RAS_EMPTY, 1'b1);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        tick();
        check("stall_jump_pc", PC, 32'h24);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check("stall_halt_run", HALTED, 1'b0);
        check("stall_halt_pc", PC, 32'h24);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check("halt_enter", HALTED, 1'b1);
        check("halt_pc", PC, 32'h24);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        tick();
        check("halt_jump_pc", PC, 32'h24);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        check("halt_ret_pc", PC, 32'h24);
        check("halt_stays", HALTED, 1'b1);
        check("err_sticky", ERR, 1'b1);
        idle();

        pulse_reset();
        for (int i = 0; i < 15; i++) tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        idle();
        check("pre_async_pc", PC, 32'h40);
        check("pre_async_empty", RAS_EMPTY, 1'b0);
        RESET = 1'b0;
        #1;
        check("async_pc", PC, 32'h0);
        check("async_empty", RAS_EMPTY, 1'b1);
        check("async_err", ERR, 1'b0);
        check("async_halted", HALTED, 1'b0);
        #1 RESET = 1'b1;
        tick();
        check("post_async_pc", PC, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
